// File: rtl/rc4_pkg.sv
// Shared constants and helpers for the RC4 keystream XOR datapath.
package rc4_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rc4_xor_stream_if.sv
// Keystream, data-in and data-out byte streams of the RC4 XOR stage.
interface rc4_xor_stream_if;
  import rc4_pkg::*;

  logic              ks_valid;
  logic [BYTE_W-1:0] ks_data;
  logic              ks_ready;
  logic              din_valid;
  logic [BYTE_W-1:0] din_data;
  logic              din_ready;
  logic              dout_valid;
  logic [BYTE_W-1:0] dout_data;
  logic              dout_ready;

  modport master (
    output ks_valid, ks_data, din_valid, din_data, dout_ready,
    input  ks_ready, din_ready, dout_valid, dout_data
  );

  modport slave (
    input  ks_valid, ks_data, din_valid, din_data, dout_ready,
    output ks_ready, din_ready, dout_valid, dout_data
  );

endinterface

// File: rtl/rc4_ks_fifo.sv
// Single-clock FIFO with synchronous flush and an explicit occupancy counter.
module rc4_ks_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == LvlW'(Depth));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rc4_xor_stream.sv
// XORs incoming data bytes with buffered RC4 keystream bytes for a programmed message length.
module rc4_xor_stream
  import rc4_pkg::*;
#(
  parameter int unsigned KS_DEPTH = 4,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LEN_W-1:0]              msg_len,
  rc4_xor_stream_if.slave               bus,
  output logic                          busy,
  output logic                          done,
  output logic [level_w(KS_DEPTH)-1:0]  ks_level
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic              dout_valid_q;
  logic [BYTE_W-1:0] dout_data_q;
  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              out_free, combine, push, flush;

  assign out_free      = !dout_valid_q || bus.dout_ready;
  assign bus.ks_ready  = (state_q != IDLE) && !fifo_full;
  assign bus.din_ready = (state_q == RUN) && !fifo_empty && out_free;
  assign combine       = bus.din_valid && bus.din_ready;
  assign push          = bus.ks_valid && bus.ks_ready;
  // Surplus keystream from the previous message is dropped on a new start.
  assign flush         = (state_q == IDLE) && start && (msg_len != '0);

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;

  rc4_ks_fifo #(
    .Depth (KS_DEPTH),
    .Width (BYTE_W)
  ) u_ks_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (combine),
    .wdata (bus.ks_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (ks_level)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (msg_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = msg_len;
          end
        end
      end
      RUN: begin
        if (combine) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      done_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      if (combine) begin
        dout_valid_q <= 1'b1;
        dout_data_q  <= bus.din_data ^ fifo_head;
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

endmodule
